// File: rtl/fme_msix_irq_sched.sv
// FME interrupt scheduler: latches per-source IRQ pulses into a pending vector and serialises
// them round-robin into posted MSI-X trigger writes on an AXI4-lite master, one write in flight.
module fme_msix_irq_sched #(
  parameter int unsigned       NUM_IRQ   = 4,
  parameter int unsigned       VEC_BASE  = 6,
  parameter int unsigned       ADDR_W    = 21,
  parameter logic [ADDR_W-1:0] MSIX_ADDR = 21'h80010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic               awvalid,
  input  logic               awready,
  output logic [ADDR_W-1:0]  awaddr,
  output logic [2:0]         awprot,
  output logic               wvalid,
  input  logic               wready,
  output logic [63:0]        wdata,
  output logic [7:0]         wstrb,
  input  logic               bvalid,
  input  logic [1:0]         bresp,
  output logic               bready,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy,
  output logic               err_sticky,
  output logic [3:0]         err_vec,
  input  logic               err_clr,
  output logic [15:0]        sent_cnt
);

  localparam int unsigned IdxW = 4;

  typedef enum logic [1:0] {StIdle, StSend, StResp} state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                err_sticky_q, err_sticky_d;
  logic [3:0]          err_vec_q, err_vec_d;
  logic [15:0]         sent_cnt_q, sent_cnt_d;

  logic [NUM_IRQ-1:0]  eligible;
  logic                grant_valid;
  logic [IdxW-1:0]     grant_idx;
  logic                grant;
  logic                aw_fin, w_fin;
  logic                b_hs;

  assign eligible = pending_q & ~irq_mask;
  assign grant    = (state_q == StIdle) && grant_valid;
  // A channel counts as finished if it completed earlier or is handshaking this cycle.
  assign aw_fin   = aw_done_q || (awvalid && awready);
  assign w_fin    = w_done_q || (wvalid && wready);
  assign b_hs     = (state_q == StResp) && bvalid;

  // Round-robin search: first eligible index at or above rr, else first below rr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!grant_valid && eligible[i] && (i >= 32'(rr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!grant_valid && eligible[i] && (i < 32'(rr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = IdxW'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StSend;
      StSend:  if (aw_fin && w_fin) state_d = StResp;
      StResp:  if (bvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; each channel drops valid once its own handshake has completed.
  always_comb begin
    awvalid = (state_q == StSend) && !aw_done_q;
    wvalid  = (state_q == StSend) && !w_done_q;
    bready  = (state_q == StResp);
    busy    = (state_q != StIdle);
  end

  // Datapath next-state: pending vector, rr pointer, grant latch, error capture, counter.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (grant && (grant_idx == IdxW'(i))) pending_d[i] = 1'b0;
    end
    // New pulses override the grant clear so a re-request is served again later.
    pending_d = pending_d | irq_req;

    rr_d  = rr_q;
    idx_d = idx_q;
    if (grant) begin
      idx_d = grant_idx;
      rr_d  = (grant_idx == IdxW'(NUM_IRQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Done flags only live inside SEND; both finishing means leaving SEND with them clear.
    aw_done_d = (state_q == StSend) && aw_fin && !w_fin;
    w_done_d  = (state_q == StSend) && w_fin && !aw_fin;

    sent_cnt_d = sent_cnt_q;
    if (b_hs) sent_cnt_d = sent_cnt_q + 16'd1;

    err_sticky_d = err_sticky_q;
    err_vec_d    = err_vec_q;
    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_vec_d    = '0;
    end
    // A new error beats a coincident clear; otherwise only the first error is recorded.
    if (b_hs && (bresp != 2'b00)) begin
      err_sticky_d = 1'b1;
      if (!err_sticky_q || err_clr) err_vec_d = idx_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      rr_q         <= '0;
      idx_q        <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      err_vec_q    <= '0;
      sent_cnt_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      rr_q         <= rr_d;
      idx_q        <= idx_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      err_sticky_q <= err_sticky_d;
      err_vec_q    <= err_vec_d;
      sent_cnt_q   <= sent_cnt_d;
    end
  end

  // Constant and registered outputs; wdata reads zero when no write is in progress.
  always_comb begin
    awaddr     = MSIX_ADDR;
    awprot     = 3'b000;
    wstrb      = 8'hFF;
    wdata      = busy ? (64'(VEC_BASE) + 64'(idx_q)) : '0;
    pending    = pending_q;
    err_sticky = err_sticky_q;
    err_vec    = err_vec_q;
    sent_cnt   = sent_cnt_q;
  end

endmodule

// File: tb/tb_fme_msix_irq_sched.sv
// Bench for fme_msix_irq_sched: directed stimulus pushes expected wdata into a queue, a monitor
// pops and compares on every W handshake, and a configurable AXI4-lite slave responds.
module tb_fme_msix_irq_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_req;
  logic [3:0]  irq_mask;
  logic        awvalid;
  logic        awready;
  logic [20:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic [3:0]  pending;
  logic        busy;
  logic        err_sticky;
  logic [3:0]  err_vec;
  logic        err_clr;
  logic [15:0] sent_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_b     = 0;
  int          exp_sent = 0;
  int          aw_delay = 0;
  int          w_delay  = 0;
  logic [1:0]  slv_bresp = 2'b00;
  logic [63:0] exp_q[$];

  fme_msix_irq_sched dut (
    .clk        (clk),
    .rst        (rst),
    .irq_req    (irq_req),
    .irq_mask   (irq_mask),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awprot     (awprot),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .bvalid     (bvalid),
    .bresp      (bresp),
    .bready     (bready),
    .pending    (pending),
    .busy       (busy),
    .err_sticky (err_sticky),
    .err_vec    (err_vec),
    .err_clr    (err_clr),
    .sent_cnt   (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
    exp_sent++;
  endtask

  // Called on a negedge; drives the request for exactly one sampling edge.
  task automatic pulse(input logic [3:0] v);
    irq_req = v;
    @(negedge clk);
    irq_req = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_sent = 0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while ((busy || ((pending & ~irq_mask) != 4'b0000)) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", cycles);
    end
    @(negedge clk);
  endtask

  task automatic wait_bready();
    int n = 0;
    while (!bready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bready) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_bready: bready=0 after %0d cycles, expected 1", n);
    end
  endtask

  // AXI4-lite slave: readies after a programmable number of wait cycles, B one cycle after bready.
  initial begin
    int aw_cnt = 0;
    int w_cnt  = 0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (awvalid) begin
        awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        awready = 1'b0;
        aw_cnt  = 0;
      end
      if (wvalid) begin
        wready = (w_cnt >= w_delay);
        w_cnt++;
      end else begin
        wready = 1'b0;
        w_cnt  = 0;
      end
      bvalid = bready;
      bresp  = bready ? slv_bresp : 2'b00;
    end
  end

  // Monitor: predicts the handshakes of the coming edge and scores them.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (awvalid && awready) begin
          check("awaddr", 64'(awaddr), 64'h80010);
          check("awprot", 64'(awprot), 64'h0);
        end
        if (wvalid && wready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: wdata=%0d, expected no write", wdata);
          end else begin
            exp = exp_q.pop_front();
            check("wdata", wdata, exp);
            check("wstrb", 64'(wstrb), 64'hFF);
          end
        end
        if (bvalid && bready) n_b++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int av;
    int wv;
    int b0;
    rst      = 1'b1;
    irq_req  = 4'b0000;
    irq_mask = 4'b0000;
    err_clr  = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_ctrl", 64'({awvalid, wvalid, bready, busy, err_sticky}), 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_err_vec", 64'(err_vec), 64'h0);
    check("rst_sent_cnt", 64'(sent_cnt), 64'h0);
    check("rst_wdata", wdata, 64'h0);
    check("rst_awaddr", 64'(awaddr), 64'h80010);
    check("rst_wstrb", 64'(wstrb), 64'hFF);

    // Single source, pulse-to-awvalid latency of two cycles
    push(64'd8);
    pulse(4'b0100);
    check("lat_awvalid_early", 64'(awvalid), 64'h0);
    @(negedge clk);
    check("lat_awvalid", 64'(awvalid), 64'h1);
    check("lat_wvalid", 64'(wvalid), 64'h1);
    wait_idle(cyc);
    check("single_sent_cnt", 64'(sent_cnt), 64'(exp_sent));
    check("single_pending", 64'(pending), 64'h0);

    // Round-robin from rr=0, three cycles per write back-to-back
    do_reset();
    push(64'd6); push(64'd7); push(64'd8); push(64'd9);
    pulse(4'b1111);
    wait_idle(cyc);
    check("rr_cycles", 64'(cyc), 64'd12);
    push(64'd6); push(64'd9);
    pulse(4'b1001);
    wait_idle(cyc);
    check("rr_sent_cnt", 64'(sent_cnt), 64'(exp_sent));

    // AW delayed three cycles, W immediate
    aw_delay = 3;
    push(64'd6);
    b0 = n_b;
    av = 0;
    wv = 0;
    pulse(4'b0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      av += int'(awvalid);
      wv += int'(wvalid);
    end
    check("hs_awvalid_cycles", 64'(av), 64'd4);
    check("hs_wvalid_cycles", 64'(wv), 64'd1);
    check("hs_b_count", 64'(n_b - b0), 64'd1);
    aw_delay = 0;

    // Re-request of [1] while its write is in RESP
    push(64'd7); push(64'd7);
    pulse(4'b0010);
    wait_bready();
    pulse(4'b0010);
    wait_idle(cyc);
    check("rereq_sent_cnt", 64'(sent_cnt), 64'(exp_sent));
    check("rereq_queue", 64'(exp_q.size()), 64'd0);

    // Pulse on the grant edge itself must survive the clear
    push(64'd8); push(64'd8);
    pulse(4'b0100);
    pulse(4'b0100);
    wait_idle(cyc);
    check("setwins_queue", 64'(exp_q.size()), 64'd0);

    // Three pulses on [1] while [0] is in flight merge into one write
    aw_delay = 3;
    push(64'd6); push(64'd7);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0010);
    pulse(4'b0010);
    wait_idle(cyc);
    check("merge_sent_cnt", 64'(sent_cnt), 64'(exp_sent));
    aw_delay = 0;

    // Masked source stays pending, then is served once unmasked
    irq_mask = 4'b0001;
    pulse(4'b0001);
    repeat (10) @(negedge clk);
    check("mask_pending", 64'(pending), 64'h1);
    check("mask_busy", 64'(busy), 64'h0);
    check("mask_sent_cnt", 64'(sent_cnt), 64'(exp_sent));
    irq_mask = 4'b0000;
    push(64'd6);
    wait_idle(cyc);
    check("unmask_sent_cnt", 64'(sent_cnt), 64'(exp_sent));
    check("unmask_pending", 64'(pending), 64'h0);

    // Error capture, first error kept, clear, and error beating a coincident clear
    slv_bresp = 2'b10;
    push(64'd6);
    pulse(4'b0001);
    wait_idle(cyc);
    check("err_sticky", 64'(err_sticky), 64'h1);
    check("err_vec", 64'(err_vec), 64'h0);
    slv_bresp = 2'b11;
    push(64'd9);
    pulse(4'b1000);
    wait_idle(cyc);
    check("err_vec_kept", 64'(err_vec), 64'h0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_sticky", 64'(err_sticky), 64'h0);
    slv_bresp = 2'b10;
    push(64'd8);
    pulse(4'b0100);
    wait_bready();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_coinc_sticky", 64'(err_sticky), 64'h1);
    check("err_coinc_vec", 64'(err_vec), 64'h2);
    slv_bresp = 2'b00;
    wait_idle(cyc);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr2_vec", 64'(err_vec), 64'h0);
    check("err_sent_cnt", 64'(sent_cnt), 64'(exp_sent));

    // Reset while in SEND abandons the write
    aw_delay = 3;
    w_delay  = 3;
    pulse(4'b0010);
    pulse(4'b1000);
    check("rsend_awvalid", 64'(awvalid), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rsend_valids", 64'({awvalid, wvalid}), 64'h0);
    check("rsend_pending", 64'(pending), 64'h0);
    check("rsend_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    exp_q.delete();
    exp_sent = 0;
    aw_delay = 0;
    w_delay  = 0;
    repeat (10) @(negedge clk);
    check("rsend_sent_cnt", 64'(sent_cnt), 64'h0);
    check("rsend_idle", 64'(busy), 64'h0);

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
